// File: rtl/cla_add_scheduler.sv
// Two-requester adder scheduler that time-multiplexes one NBIT carry-lookahead
// slice across NWORDS words, least significant word first.
module cla_adder #(
    parameter int NBIT = 4
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    output logic [NBIT-1:0] s,
    output logic            cout
);
    logic [NBIT-1:0] p;
    logic [NBIT-1:0] g;
    logic [NBIT:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // each carry is a flat sum of generate terms, not a ripple chain
    always_comb begin
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b0;
        c   = '0;
        c[0] = cin;
        for (int i = 0; i < NBIT; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign s    = p ^ c[NBIT-1:0];
    assign cout = c[NBIT];
endmodule

module cla_add_scheduler #(
    parameter int NBIT   = 4,
    parameter int NWORDS = 4,
    parameter int W      = NBIT * NWORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_id
);
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state;
    logic            prio;
    logic [KW-1:0]   k;
    logic            carry;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic            grant;
    logic            accept;
    logic [NBIT-1:0] add_s;
    logic            add_c;

    always_comb begin
        grant = prio;
        if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (req1_valid && !req0_valid)
            grant = 1'b1;
    end

    assign req0_ready = (state == IDLE) && !grant;
    assign req1_ready = (state == IDLE) && grant;
    assign accept = (req0_valid && req0_ready)
                  || (req1_valid && req1_ready);

    // operands shift down so word k always sits in the low slice
    cla_adder #(.NBIT(NBIT)) u_add (
        .a    (op_a[NBIT-1:0]),
        .b    (op_b[NBIT-1:0]),
        .cin  (carry),
        .s    (add_s),
        .cout (add_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            k         <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a   <= grant ? req1_a : req0_a;
                        op_b   <= grant ? req1_b : req0_b;
                        carry  <= grant ? req1_cin : req0_cin;
                        rsp_id <= grant;
                        k      <= '0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    op_a    <= op_a >> NBIT;
                    op_b    <= op_b >> NBIT;
                    rsp_sum <= {add_s, rsp_sum[W-1:NBIT]};
                    carry   <= add_c;
                    k       <= k + 1'b1;
                    if (k == KLAST) begin
                        k         <= '0;
                        rsp_cout  <= add_c;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        prio      <= ~rsp_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
